// File: rtl/seq_pattern_streamer.sv
`timescale 1ns/1ps
// seq_pattern_streamer
// Captures a PAT_W-bit pattern on a synchronised rising edge of the load
// button and shifts it out MSB-first, one bit per TICK_DIV clock cycles.
// A one-cycle step strobe marks when bit_out is valid, so a downstream
// detector can run on clk with step as its clock enable.
//
// Handshake: there is no back-pressure. step is a pure valid strobe. The
// consumer must take bit_out/bit_idx in every cycle in which step is high.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   load       : asynchronous push-button; only its synchronised rising edge acts
//   pattern_in : pattern, sampled only when a load is accepted
//   repeat_en  : replay the captured pattern continuously (sampled at the last bit)
//   bit_out    : serial data (the MSB of the working shift register while streaming)
//   step       : one-cycle strobe, bit_out valid in this cycle
//   busy       : high while streaming
//   done       : one-cycle pulse after the last bit of a non-repeating run
//   bit_idx    : index of the bit on bit_out, 0 = MSB
//   dbg_state  : FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module seq_pattern_streamer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PAT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [PAT_W-1:0]         pattern_in,
  input  logic                     repeat_en,
  output logic                     bit_out,
  output logic                     step,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(PAT_W)-1:0] bit_idx,
  output logic [1:0]               dbg_state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(PAT_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat_cap;
  logic [PAT_W-1:0] r_shreg;
  logic [TW-1:0]    r_tick_cnt;
  logic [BW-1:0]    r_bit_cnt;

  // Two-flop synchroniser followed by an edge-detect delay flop.
  logic r_load_m;
  logic r_load_s;
  logic r_load_d;

  logic w_load_pulse;
  logic w_tick_last;
  logic w_last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_m <= 1'b0;
      r_load_s <= 1'b0;
      r_load_d <= 1'b0;
    end else begin
      r_load_m <= load;
      r_load_s <= r_load_m;
      r_load_d <= r_load_s;
    end
  end

  assign w_load_pulse = r_load_s & ~r_load_d;
  assign w_tick_last  = (r_tick_cnt == TICK_LAST);
  assign w_last_bit   = (r_bit_cnt == BIT_LAST);

  // A load pulse takes priority over everything else, in every state, so an
  // accepted load always aborts the current run (no done, no replay).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pat_cap  <= '0;
      r_shreg    <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_load_pulse) begin
      r_pat_cap  <= pattern_in;
      r_shreg    <= pattern_in;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
      r_state    <= SHIFT;
    end else begin
      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
        end
        SHIFT: begin
          if (w_tick_last) begin
            r_tick_cnt <= '0;
            if (w_last_bit && repeat_en) begin
              // Replay with no gap: the next cycle already shows the MSB.
              r_shreg   <= r_pat_cap;
              r_bit_cnt <= '0;
            end else begin
              r_shreg   <= {r_shreg[PAT_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + BW'(1);
              if (w_last_bit) begin
                r_state <= DONE;
              end
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        DONE: begin
          r_tick_cnt <= '0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so an asynchronous reset
  // clears them in the same cycle it is asserted.
  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign step      = busy & w_tick_last;
  assign bit_out   = busy & r_shreg[PAT_W-1];
  assign bit_idx   = busy ? r_bit_cnt : '0;
  assign dbg_state = r_state;

endmodule
